// File: rtl/bcd_ctrl_pkg.sv
// rtl/bcd_ctrl_pkg.sv - shared state encodings and BCD constants for the BCD count controller
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic       MODE_UP = 1'b0;
    localparam logic       MODE_DN = 1'b1;

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit step with carry/borrow in and out
module bcd_digit_cell
    import bcd_ctrl_pkg::*;
(
    input  logic       en,
    input  logic       mode,
    input  logic       clr,
    input  logic [3:0] value,
    output logic [3:0] value_nxt,
    output logic       cout
);

    // codes above 9 behave as 9 in both directions
    always_comb begin
        value_nxt = value;
        cout      = 1'b0;
        if (clr) begin
            value_nxt = 4'd0;
        end else if (en) begin
            if (mode == MODE_UP) begin
                if (value >= BCD_MAX) begin
                    value_nxt = 4'd0;
                    cout      = 1'b1;
                end else begin
                    value_nxt = value + 4'd1;
                end
            end else begin
                if (value == 4'd0) begin
                    value_nxt = BCD_MAX;
                    cout      = 1'b1;
                end else if (value > BCD_MAX) begin
                    value_nxt = BCD_MAX - 4'd1;
                end else begin
                    value_nxt = value - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - run/stop/clear BCD counter chain with display scan; BCD_CTRL_SATURATE_EN stops at the limit
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                start_btn,
    input  logic                stop_btn,
    input  logic                clr_btn,
    input  logic                mode,
    output logic                running,
    output logic                tick,
    output logic                wrap,
    output logic [4*NDIG-1:0]   count,
    output logic [NDIG-1:0]     an,
    output logic [3:0]          dig_bcd
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int QW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(NDIG);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [QW-1:0]   SCAN_LAST  = QW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]   SEL_LAST   = SW'(NDIG - 1);
    localparam logic [NDIG-1:0] AN_RST     = ~NDIG'(1);

    state_t            state, state_nxt;
    logic [2:0]        btn_s, btn_p, btn_ev;
    logic              start_ev, stop_ev, clr_ev;
    logic [PW-1:0]     presc;
    logic [QW-1:0]     scan_cnt;
    logic [SW-1:0]     sel, sel_nxt;
    logic [NDIG:0]     carry;
    logic [4*NDIG-1:0] count_step, count_d;
    logic              tick_hit, at_limit, hold, step_en;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            btn_s <= '0;
            btn_p <= '0;
        end else begin
            btn_s <= {clr_btn, stop_btn, start_btn};
            btn_p <= btn_s;
        end
    end

    assign btn_ev   = btn_s & ~btn_p;
    assign start_ev = btn_ev[0];
    assign stop_ev  = btn_ev[1];
    assign clr_ev   = btn_ev[2];

    // carry out of the top cell means the chain sits at its limit for the current mode
    assign carry[0] = 1'b1;
    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_digit_cell u_cell (
            .en        (carry[g]),
            .mode      (mode),
            .clr       (clr_ev),
            .value     (count[4*g +: 4]),
            .value_nxt (count_step[4*g +: 4]),
            .cout      (carry[g+1])
        );
    end
    assign at_limit = carry[NDIG];

`ifdef BCD_CTRL_SATURATE_EN
    assign hold = at_limit;
`else
    assign hold = 1'b0;
`endif

    assign tick_hit = (state == ST_RUN) && (presc == PRESC_LAST);
    assign step_en  = tick_hit && !hold;
    assign count_d  = (clr_ev || step_en) ? count_step : count;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr_ev) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:  if (start_ev) state_nxt = ST_RUN;
                ST_RUN:   if (stop_ev || (tick_hit && hold)) state_nxt = ST_PAUSE;
                ST_PAUSE: if (start_ev && !hold) state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    // pause keeps the prescaler phase; only a fresh start or clr zeroes it
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            tick  <= tick_hit && !clr_ev;
            wrap  <= tick_hit && !clr_ev && at_limit;
            if (clr_ev || ((state == ST_IDLE) && start_ev)) begin
                presc <= '0;
            end else if (state == ST_RUN) begin
                presc <= tick_hit ? '0 : presc + PW'(1);
            end
        end
    end

    always_comb begin
        sel_nxt = sel;
        if (scan_cnt == SCAN_LAST) begin
            sel_nxt = (sel == SEL_LAST) ? '0 : sel + SW'(1);
        end
    end

    // dig_bcd follows the next count so it never lags the enabled digit
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            sel      <= '0;
            an       <= AN_RST;
            dig_bcd  <= 4'd0;
        end else begin
            scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + QW'(1);
            sel      <= sel_nxt;
            an       <= ~(NDIG'(1) << sel_nxt);
            dig_bcd  <= count_d[4*sel_nxt +: 4];
        end
    end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - directed self-checking bench for bcd_count_ctrl (NDIG=2, TICK_DIV=4, SCAN_DIV=2)
module tb_bcd_count_ctrl;

    logic       mclk = 1'b0;
    logic       rst, start_btn, stop_btn, clr_btn, mode;
    logic       running, tick, wrap;
    logic [7:0] count;
    logic [1:0] an;
    logic [3:0] dig_bcd;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    logic [7:0] exp_pause, exp_resume;

    bcd_count_ctrl #(.NDIG(2), .TICK_DIV(4), .SCAN_DIV(2)) dut (
        .mclk      (mclk),
        .rst       (rst),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .clr_btn   (clr_btn),
        .mode      (mode),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .count     (count),
        .an        (an),
        .dig_bcd   (dig_bcd)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
            ecount++;
        end
    endtask

    function automatic logic [7:0] bcd2(input int k);
        return {4'(k / 10), 4'(k % 10)};
    endfunction

    // the scan slot advances every second edge counted from reset release
    task automatic chk_scan(input logic [7:0] exp);
        int s;
        s = (ecount / 2) % 2;
        chk("an", an, (s == 1) ? 2'b01 : 2'b10);
        chk("dig_bcd", dig_bcd, (s == 1) ? exp[7:4] : exp[3:0]);
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; clr_btn = 1'b0; mode = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_count", count, 8'h00);
        chk("rst_running", running, 1'b0);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_an", an, 2'b10);
        chk("rst_dig", dig_bcd, 4'd0);
        rst = 1'b0;
        ecount = 0;

        start_btn = 1'b1;
        step(1); chk("run_e1", running, 1'b0); chk_scan(8'h00);
        step(1); chk("run_e2", running, 1'b1); chk_scan(8'h00);
        start_btn = 1'b0;
        step(3); chk("tick_pre", tick, 1'b0); chk("cnt_pre", count, 8'h00);
        step(1); chk("tick_first", tick, 1'b1); chk("cnt_first", count, 8'h01); chk("wrap_first", wrap, 1'b0);
        for (int k = 2; k <= 99; k++) begin
            step(2); chk_scan(bcd2(k - 1));
            step(1); chk("tick_gap", tick, 1'b0);
            step(1); chk("cnt_up", count, bcd2(k)); chk_scan(bcd2(k));
        end

`ifndef BCD_CTRL_SATURATE_EN
        step(4); chk("roll_cnt", count, 8'h00); chk("roll_wrap", wrap, 1'b1); chk("roll_tick", tick, 1'b1);
        step(1); chk("roll_wrap_end", wrap, 1'b0);
        mode = 1'b1;
        step(3); chk("dn_roll_cnt", count, 8'h99); chk("dn_roll_wrap", wrap, 1'b1);
        mode = 1'b0;
        step(4); chk("up_roll_cnt", count, 8'h00); chk("up_roll_wrap", wrap, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(4); chk("cnt_up2", count, bcd2(k));
        end
        mode = 1'b1;
        step(4); chk("borrow_cnt", count, 8'h09); chk("borrow_wrap", wrap, 1'b0);
        mode = 1'b0;
        exp_pause = 8'h09; exp_resume = 8'h10;
`else
        step(4); chk("sat_cnt", count, 8'h99); chk("sat_wrap", wrap, 1'b1); chk("sat_run", running, 1'b0);
        step(1); chk("sat_wrap_end", wrap, 1'b0);
        start_btn = 1'b1;
        step(2); chk("sat_ignore", running, 1'b0);
        start_btn = 1'b0; mode = 1'b1;
        step(1);
        start_btn = 1'b1;
        step(2); chk("sat_resume", running, 1'b1);
        start_btn = 1'b0;
        step(4); chk("sat_dn_cnt", count, 8'h98); chk("sat_dn_tick", tick, 1'b1);
        mode = 1'b0;
        exp_pause = 8'h98; exp_resume = 8'h99;
`endif

        stop_btn = 1'b1;
        step(2); chk("pause_run", running, 1'b0);
        stop_btn = 1'b0;
        step(6); chk("pause_cnt", count, exp_pause); chk("pause_tick", tick, 1'b0); chk("pause_run2", running, 1'b0);
        start_btn = 1'b1;
        step(2); chk("resume_run", running, 1'b1); chk("resume_tick0", tick, 1'b0);
        step(1); chk("resume_tick1", tick, 1'b0);
        start_btn = 1'b0;
        step(1); chk("resume_tick2", tick, 1'b1); chk("resume_cnt", count, exp_resume);

        clr_btn = 1'b1;
        step(1); chk_scan(exp_resume);
        step(1); chk("clr_cnt", count, 8'h00); chk("clr_run", running, 1'b0); chk_scan(8'h00);
        clr_btn = 1'b0;
        step(1); chk_scan(8'h00);
        start_btn = 1'b1;
        step(2); chk("restart_run", running, 1'b1);
        start_btn = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            step(4); chk("cnt_37", count, bcd2(k));
        end
        step(2);
        clr_btn = 1'b1; stop_btn = 1'b1; start_btn = 1'b1;
        step(1); chk("multi_pre_cnt", count, 8'h37); chk("multi_pre_run", running, 1'b1); chk("multi_pre_tick", tick, 1'b0);
        step(1); chk("multi_cnt", count, 8'h00); chk("multi_tick", tick, 1'b0); chk("multi_wrap", wrap, 1'b0);
        chk("multi_run", running, 1'b0); chk_scan(8'h00);
        clr_btn = 1'b0; stop_btn = 1'b0; start_btn = 1'b0;
        step(4); chk("idle_cnt", count, 8'h00); chk("idle_run", running, 1'b0); chk("idle_tick", tick, 1'b0);

        step(1);
        start_btn = 1'b1;
        step(2); chk("final_run", running, 1'b1);
        start_btn = 1'b0;
        step(4); chk("final_cnt", count, 8'h01); chk("final_tick", tick, 1'b1);
        step(1);
        #3 rst = 1'b1;
        #1;
        chk("async_cnt", count, 8'h00);
        chk("async_run", running, 1'b0);
        chk("async_tick", tick, 1'b0);
        chk("async_an", an, 2'b10);
        chk("async_dig", dig_bcd, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
